// File: rtl/unsigned_div_iter.sv
// unsigned_div_iter: multi-cycle radix-2 restoring unsigned divider, dout = {quotient, remainder}
module unsigned_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] rem, q, d, dvd, dvs, shifted, rem_n, q_n;
  logic [WIDTH:0]   t;
  logic             dvd_held, dvs_held, dvd_fire, dvs_fire;
  logic [CW-1:0]    count;
  // tready is gated by resetn so both channels read as busy while reset is held
  assign s_axis_dividend_tready = resetn && state == IDLE && !dvd_held;
  assign s_axis_divisor_tready  = resetn && state == IDLE && !dvs_held;
  assign dvd_fire = s_axis_dividend_tvalid && s_axis_dividend_tready;
  assign dvs_fire = s_axis_divisor_tvalid && s_axis_divisor_tready;
  assign shifted  = {rem[WIDTH-2:0], q[WIDTH-1]};
  assign t        = {1'b0, shifted} - {1'b0, d};
  assign rem_n    = t[WIDTH] ? shifted : t[WIDTH-1:0];
  assign q_n      = {q[WIDTH-2:0], ~t[WIDTH]};
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state              <= IDLE;
      dvd_held           <= 1'b0;
      dvs_held           <= 1'b0;
      dvd                <= '0;
      dvs                <= '0;
      rem                <= '0;
      q                  <= '0;
      d                  <= '0;
      count              <= '0;
      m_axis_dout_tdata  <= '0;
      m_axis_dout_tvalid <= 1'b0;
    end else begin
      m_axis_dout_tvalid <= 1'b0;
      case (state)
        IDLE: begin
          if ((dvd_held || dvd_fire) && (dvs_held || dvs_fire)) begin
            rem      <= '0;
            q        <= dvd_held ? dvd : s_axis_dividend_tdata;
            d        <= dvs_held ? dvs : s_axis_divisor_tdata;
            count    <= '0;
            dvd_held <= 1'b0;
            dvs_held <= 1'b0;
            state    <= CALC;
          end else begin
            if (dvd_fire) begin
              dvd      <= s_axis_dividend_tdata;
              dvd_held <= 1'b1;
            end
            if (dvs_fire) begin
              dvs      <= s_axis_divisor_tdata;
              dvs_held <= 1'b1;
            end
          end
        end
        CALC: begin
          rem   <= rem_n;
          q     <= q_n;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            m_axis_dout_tdata  <= {q_n, rem_n};
            m_axis_dout_tvalid <= 1'b1;
            state              <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
